// File: rtl/key_pkg.sv
// Shared defaults and counter-width helpers for the key debounce slice.
package key_pkg;

  localparam int unsigned NUM_KEYS_DEF       = 16;
  localparam int unsigned CLK_DIV_DEF        = 1_000_000;
  localparam int unsigned STABLE_SAMPLES_DEF = 3;
  localparam int unsigned ACTIVE_LOW_DEF     = 1;
  localparam int unsigned LONG_TICKS_DEF     = 50;
  localparam int unsigned CNT_W_DEF          = 8;

  // Bits needed to hold every value 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DIV_W_DEF  = cnt_w(CLK_DIV_DEF - 1);
  localparam int unsigned STAB_W_DEF = cnt_w(STABLE_SAMPLES_DEF);
  localparam int unsigned HOLD_W_DEF = cnt_w(LONG_TICKS_DEF);

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: synchroniser, stability counter, debounced level,
// press/release pulses and long-press hold counter.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int unsigned ACTIVE_LOW     = ACTIVE_LOW_DEF,
  parameter int unsigned LONG_TICKS     = LONG_TICKS_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic key_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned STAB_W   = cnt_w(STABLE_SAMPLES);
  localparam int unsigned HOLD_W   = cnt_w(LONG_TICKS);
  // Raw level of an untouched key; also the synchroniser reset value.
  localparam logic        IDLE_LVL = (ACTIVE_LOW != 0);

  logic [1:0]        sync_q;
  logic              sample;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

  // Normalised to 1 = pressed.
  assign sample = sync_q[1] ^ IDLE_LVL;

  // Two-flop synchroniser for the asynchronous key input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {2{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  // Debounce and hold next-state; pulses default low so they last one cycle.
  always_comb begin
    stab_d  = stab_q;
    hold_d  = hold_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    if (tick) begin
      if (sample != level_q) begin
        if (stab_q == STAB_W'(STABLE_SAMPLES - 1)) begin
          level_d = ~level_q;
          stab_d  = '0;
          press_d = ~level_q;
          rel_d   = level_q;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end else begin
        stab_d = '0;
      end
    end
    if (!level_q) begin
      hold_d = '0;
    end else if (tick && (hold_q != HOLD_W'(LONG_TICKS))) begin
      // Saturation at LONG_TICKS makes the long pulse fire once per hold.
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_W'(LONG_TICKS - 1));
    end
  end

  // Per-key state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stab_q  <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/key_debounce_n.sv
// Multi-key debouncer: shared sample-tick divider, per-key cells and a
// saturating press counter.
module key_debounce_n
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = NUM_KEYS_DEF,
  parameter int unsigned CLK_DIV        = CLK_DIV_DEF,
  parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int unsigned ACTIVE_LOW     = ACTIVE_LOW_DEF,
  parameter int unsigned LONG_TICKS     = LONG_TICKS_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                clr_count,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [CNT_W-1:0]    press_count,
  output logic                sample_tick
);

  localparam int unsigned DIV_W = cnt_w(CLK_DIV - 1);
  localparam int unsigned POP_W = cnt_w(NUM_KEYS);
  localparam int unsigned SUM_W = CNT_W + POP_W;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  assign sample_tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Divider wraps after the tick cycle.
  always_comb begin
    div_d = div_q + 1'b1;
    if (sample_tick) begin
      div_d = '0;
    end
  end

  // Popcount of this cycle's press pulses, added with saturation; clear wins.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      pop = pop + POP_W'(key_press[i]);
    end
    sum   = SUM_W'(cnt_q) + SUM_W'(pop);
    cnt_d = sum[CNT_W-1:0];
    if (sum > SUM_W'({CNT_W{1'b1}})) begin
      cnt_d = '1;
    end
    if (clr_count) begin
      cnt_d = '0;
    end
  end

  // Divider and press counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign press_count = cnt_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_cell #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .LONG_TICKS    (LONG_TICKS)
    ) u_cell (
      .clk          (clk),
      .rstn         (rstn),
      .tick         (sample_tick),
      .key_raw      (key_in[k]),
      .level        (key_level[k]),
      .press_pulse  (key_press[k]),
      .release_pulse(key_release[k]),
      .long_pulse   (key_long[k])
    );
  end

endmodule

// File: tb/tb_key_debounce_n.sv
// Tick-stepped bench: one vector per sample tick, expectations queued on drive
// and compared after the following tick edge.
module tb_key_debounce_n;

  localparam int unsigned NK      = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NVEC    = 41;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [NK-1:0] key_in = 4'hF;
  logic          clr_count = 1'b0;
  logic [NK-1:0] key_level, key_press, key_release, key_long;
  logic [2:0]    press_count;
  logic          sample_tick;

  key_debounce_n #(
    .NUM_KEYS      (NK),
    .CLK_DIV       (CLK_DIV),
    .STABLE_SAMPLES(3),
    .ACTIVE_LOW    (1),
    .LONG_TICKS    (5),
    .CNT_W         (3)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_in     (key_in),
    .clr_count  (clr_count),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .press_count(press_count),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;
    logic       clr;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[NVEC];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step     = 0;

  function automatic vec_t mk(input logic [3:0] keys, input logic clr, input logic [3:0] lvl,
                              input logic [3:0] prs, input logic [3:0] rel,
                              input logic [3:0] lng, input logic [2:0] cnt);
    vec_t v;
    v.keys = keys; v.clr = clr; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h, want 0x%0h", name, idx, act, req);
  endtask

  // Advance to just after the next sample-tick edge, counting cycles and pulse cycles.
  task automatic run_tick(output int ncyc, output int npulse, output bit timed_out);
    bit tick_before;
    ncyc = 0;
    npulse = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick_before = sample_tick;
      @(posedge clk);
      #1;
      ncyc++;
      if ((key_press | key_release | key_long) != '0) npulse++;
      if (tick_before) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    int   ncyc, npulse;
    bit   to;
    key_in    = v.keys;
    clr_count = v.clr;
    exp_q.push_back(v);
    run_tick(ncyc, npulse, to);
    e = exp_q.pop_front();
    check("tick_timeout", step, 32'(to), 32'(0));
    check("tick_period", step, 32'(ncyc), 32'(CLK_DIV));
    check("key_level", step, 32'(key_level), 32'(e.lvl));
    check("key_press", step, 32'(key_press), 32'(e.prs));
    check("key_release", step, 32'(key_release), 32'(e.rel));
    check("key_long", step, 32'(key_long), 32'(e.lng));
    check("press_count", step, 32'(press_count), 32'(e.cnt));
    check("pulse_cycles", step, 32'(npulse), ((e.prs | e.rel | e.lng) != '0) ? 32'(1) : 32'(0));
    step++;
  endtask

  task automatic check_all_zero(input int idx);
    check("rst_level", idx, 32'(key_level), 32'(0));
    check("rst_press", idx, 32'(key_press), 32'(0));
    check("rst_release", idx, 32'(key_release), 32'(0));
    check("rst_long", idx, 32'(key_long), 32'(0));
    check("rst_count", idx, 32'(press_count), 32'(0));
    check("rst_tick", idx, 32'(sample_tick), 32'(0));
  endtask

  // Reset entered mid-interval; outputs must drop at once.
  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_all_zero(step);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // keys, clr, level, press, release, long, count
    vecs[0]  = mk(4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
    vecs[1]  = mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);  // key0 pressed
    vecs[2]  = mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);
    vecs[3]  = mk(4'hE, 0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd0);  // 3rd sample
    vecs[4]  = mk(4'hC, 0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd1);  // key1 glitch start
    vecs[5]  = mk(4'hD, 0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd1);  // key0 released
    vecs[6]  = mk(4'hF, 0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd1);  // key1 glitch over
    vecs[7]  = mk(4'hF, 0, 4'h0, 4'h0, 4'h1, 4'h0, 3'd1);
    vecs[8]  = mk(4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd1);
    vecs[9]  = mk(4'hB, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd1);  // key2 long hold
    vecs[10] = mk(4'hB, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd1);
    vecs[11] = mk(4'hB, 0, 4'h4, 4'h4, 4'h0, 4'h0, 3'd1);
    vecs[12] = mk(4'hB, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[13] = mk(4'hB, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[14] = mk(4'hB, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[15] = mk(4'hB, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[16] = mk(4'hB, 0, 4'h4, 4'h0, 4'h0, 4'h4, 3'd2);  // 5 ticks after rise
    vecs[17] = mk(4'hB, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[18] = mk(4'hB, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[19] = mk(4'hF, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[20] = mk(4'hF, 0, 4'h4, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[21] = mk(4'hF, 0, 4'h0, 4'h0, 4'h4, 4'h0, 3'd2);
    vecs[22] = mk(4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd2);  // all keys together
    vecs[23] = mk(4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd2);
    vecs[24] = mk(4'h0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 3'd2);
    vecs[25] = mk(4'hF, 0, 4'hF, 4'h0, 4'h0, 4'h0, 3'd6);
    vecs[26] = mk(4'hF, 0, 4'hF, 4'h0, 4'h0, 4'h0, 3'd6);
    vecs[27] = mk(4'hF, 0, 4'h0, 4'h0, 4'hF, 4'h0, 3'd6);
    vecs[28] = mk(4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd6);
    vecs[29] = mk(4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd6);
    vecs[30] = mk(4'h0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 3'd6);
    vecs[31] = mk(4'hF, 0, 4'hF, 4'h0, 4'h0, 4'h0, 3'd7);  // saturated
    vecs[32] = mk(4'hF, 0, 4'hF, 4'h0, 4'h0, 4'h0, 3'd7);
    vecs[33] = mk(4'hF, 0, 4'h0, 4'h0, 4'hF, 4'h0, 3'd7);
    vecs[34] = mk(4'h7, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd7);  // key3 press under clear
    vecs[35] = mk(4'h7, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd7);
    vecs[36] = mk(4'h7, 1, 4'h8, 4'h8, 4'h0, 4'h0, 3'd0);
    vecs[37] = mk(4'hF, 1, 4'h8, 4'h0, 4'h0, 4'h0, 3'd0);
    vecs[38] = mk(4'hF, 0, 4'h8, 4'h0, 4'h0, 4'h0, 3'd0);
    vecs[39] = mk(4'hF, 0, 4'h0, 4'h0, 4'h8, 4'h0, 3'd0);
    vecs[40] = mk(4'hF, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0);

    #2;
    rstn = 1'b0;
    #1;
    check_all_zero(-1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NVEC; i++) apply(vecs[i]);

    // Reset mid-hold, then mid-debounce, with key0 held throughout.
    apply(mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0));
    apply(mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0));
    apply(mk(4'hE, 0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd0));
    apply(mk(4'hE, 0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd1));
    apply(mk(4'hE, 0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd1));
    reset_pulse();
    apply(mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0));
    apply(mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0));
    reset_pulse();
    apply(mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0));
    apply(mk(4'hE, 0, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0));
    apply(mk(4'hE, 0, 4'h1, 4'h1, 4'h0, 4'h0, 3'd0));
    for (int i = 0; i < 4; i++) apply(mk(4'hE, 0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd1));
    apply(mk(4'hE, 0, 4'h1, 4'h0, 4'h0, 4'h1, 3'd1));
    apply(mk(4'hE, 0, 4'h1, 4'h0, 4'h0, 4'h0, 3'd1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_debounce_n.md
KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 16: number of independent key channels.
REQ-002 SHALL have parameter CLK_DIV, default 1_000_000: clk cycles per sample tick (20 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_SAMPLES, default 3: consecutive differing samples required to change a debounced level.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = raw key reads 0 when pressed.
REQ-005 SHALL have parameter LONG_TICKS, default 50: ticks a key must stay pressed to fire a long-press pulse.
REQ-006 SHALL have parameter CNT_W, default 8: width of press_count.
REQ-007 SHALL have port clk  input  1  system clock.
REQ-008 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port key_in  input  NUM_KEYS  raw asynchronous key levels.
REQ-010 SHALL have port clr_count  input  1  synchronous clear of press_count.
REQ-011 SHALL have port key_level  output  NUM_KEYS  debounced level, 1 = pressed, independent of ACTIVE_LOW.
REQ-012 SHALL have port key_press  output  NUM_KEYS  one-clk pulse on a debounced press.
REQ-013 SHALL have port key_release  output  NUM_KEYS  one-clk pulse on a debounced release.
REQ-014 SHALL have port key_long  output  NUM_KEYS  one-clk pulse on reaching long-press duration.
REQ-015 SHALL have port press_count  output  CNT_W  saturating total of press events over all keys.
REQ-016 SHALL have port sample_tick  output  1  one-clk pulse marking each sample instant.

Function
REQ-017 Tick divider SHALL count 0..CLK_DIV-1 and wrap; sample_tick SHALL be 1 exactly in the cycle the count equals CLK_DIV-1.
REQ-018 Each key_in bit SHALL pass a 2-flop synchroniser every clk, then be normalised to active-high per ACTIVE_LOW.
REQ-019 Per key, on a tick: normalised sample != key_level increments a stability counter; sample == key_level clears it.
REQ-020 When the increment would make the counter equal STABLE_SAMPLES, key_level SHALL toggle on that same clk edge and the counter SHALL clear; a glitch shorter than STABLE_SAMPLES ticks SHALL never change key_level.
REQ-021 key_press/key_release SHALL be 1 for exactly the clk cycle following the edge at which key_level rises/falls (registered in the same update); no pulses between ticks otherwise.
REQ-022 Per key, a hold counter SHALL clear while key_level=0 and increment on each tick while key_level=1, saturating at LONG_TICKS.
REQ-023 key_long SHALL pulse once per hold, in the cycle the hold counter reaches LONG_TICKS; it SHALL not repeat until the key is released and pressed again.
REQ-024 press_count SHALL add the popcount of key_press each cycle, saturating at 2^CNT_W-1 (no wrap).
REQ-025 clr_count SHALL take priority: press_count becomes 0 next cycle even if key_press is set that cycle.
REQ-026 Keys SHALL be fully independent; simultaneous events on several keys SHALL all be reported in the same cycle.

Reset
REQ-027 rstn low SHALL asynchronously force: divider 0, synchroniser flops to released level, stability and hold counters 0, key_level 0, key_press/key_release/key_long 0, press_count 0, sample_tick 0.
REQ-028 A key held pressed through reset release SHALL be reported as a fresh press after STABLE_SAMPLES ticks.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard all partial counts; no pulse SHALL be emitted on reset entry or exit.

Structure
REQ-030 Default parameter values and the clog2-based counter-width constants SHALL live in shared package key_pkg.
REQ-031 Per-key logic (synchroniser, stability counter, level, edge pulses, hold counter) SHALL be sub-module key_debounce_cell, instantiated NUM_KEYS times; divider and press_count remain in the top.

Verification
REQ-032 Bench SHALL use CLK_DIV=4, STABLE_SAMPLES=3, LONG_TICKS=5, NUM_KEYS=4, ACTIVE_LOW=1, CNT_W=3 unless stated.
REQ-033 key_in[0] 1->0 held -> key_level[0]=1 on the 3rd tick after sync latency; key_press[0] one cycle; press_count=1.
REQ-034 key_in[1] low for 2 ticks then high -> key_level[1] stays 0, no pulses.
REQ-035 key_in[2] held low 8 ticks -> key_press at tick 3, single key_long at 5 ticks after key_level rose, none after; release -> key_release after 3 ticks.
REQ-036 keys 0..3 pressed together, repeated twice -> 4 key_press bits in one cycle; press_count saturates at 7; clr_count with a simultaneous press -> press_count=0.
REQ-037 rstn pulsed low mid-debounce with key_in[0]=0 -> all outputs 0 immediately; press re-detected 3 ticks after release of reset.
